// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiplier controller for the MUL ALU operation.
// Holds the pipeline via stall_o while iterating, then pulses done_o with the low WIDTH product bits.
module mul_sequencer #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] mcand_nx;
  logic [WIDTH-1:0] mplier_nx;
  logic [WIDTH-1:0] acc_nx;

  // One RUN cycle retires BITS_PER_CYCLE multiplier bits; sums wrap mod 2^WIDTH.
  always_comb begin
    mcand_nx  = mcand;
    mplier_nx = mplier;
    acc_nx    = acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_nx[0]) acc_nx = acc_nx + mcand_nx;
      mcand_nx  = mcand_nx << 1;
      mplier_nx = mplier_nx >> 1;
    end
  end

  // Stall must rise in the same cycle the MUL is first seen, so it is not registered.
  assign stall_o = rst_i & ~flush_i & (((state == IDLE) & start_i) | (state == RUN));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      result_o <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i && !flush_i) begin
            mcand  <= data1_i;
            mplier <= data2_i;
            acc    <= '0;
            count  <= '0;
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (flush_i) begin
            count  <= '0;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            mcand  <= mcand_nx;
            mplier <= mplier_nx;
            acc    <= acc_nx;
            count  <= count + 1'b1;
            if (count == LAST) begin
              result_o <= acc_nx;
              busy_o   <= 1'b0;
              done_o   <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          // start_i is still high from the completing instruction, so it is ignored here.
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: stimulus pushes expected results, monitors pop on done_o.
// A second instance covers the two-bits-per-cycle configuration.
module tb_mul_sequencer;

  typedef struct {
    logic [31:0] res;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [31:0] data1, data2;
  logic        stall, busy, done;
  logic [31:0] result;

  logic        start2;
  logic [31:0] a2, b2;
  logic        stall2, busy2, done2;
  logic [31:0] result2;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .flush_i(flush),
    .data1_i(data1), .data2_i(data2),
    .stall_o(stall), .busy_o(busy), .done_o(done), .result_o(result)
  );

  mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut2 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start2), .flush_i(1'b0),
    .data1_i(a2), .data2_i(b2),
    .stall_o(stall2), .busy_o(busy2), .done_o(done2), .result_o(result2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the one-bit-per-cycle instance: latency T..DONE is N+1 = 33.
  always @(negedge clk) begin
    if (done) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_result", result, e1.res);
        chk("dut1_done_latency", 32'(cyc - e1.t), 32'd33);
      end
    end
  end

  // Monitor for the two-bits-per-cycle instance: latency 17.
  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        chk("dut2_unexpected_done", 32'd1, 32'd0);
      end else begin
        e2 = q2.pop_front();
        chk("dut2_result", result2, e2.res);
        chk("dut2_done_latency", 32'(cyc - e2.t), 32'd17);
      end
    end
  end

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit keep);
    int stall_n = 0;
    int busy_n  = 0;
    bit got     = 0;
    @(posedge clk); #1;
    start = 1'b1; data1 = a; data2 = b;
    q1.push_back('{exp, cyc});
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (k == 3) begin
        data1 = ~a; data2 = ~b;
      end
      if (done) begin
        got = 1;
        chk("done_cycle_stall", {31'd0, stall}, 32'd0);
        chk("done_cycle_busy", {31'd0, busy}, 32'd0);
      end else begin
        if (stall) stall_n++;
        if (busy) busy_n++;
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("stall_cycles", 32'(stall_n), 32'd33);
    chk("busy_cycles", 32'(busy_n), 32'd32);
    if (!keep) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic do_mul2(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int stall_n = 0;
    bit got     = 0;
    @(posedge clk); #1;
    start2 = 1'b1; a2 = a; b2 = b;
    q2.push_back('{exp, cyc});
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (done2) got = 1;
      else if (stall2) stall_n++;
    end
    chk("dut2_done_seen", {31'd0, got}, 32'd1);
    chk("dut2_stall_cycles", 32'(stall_n), 32'd17);
    @(posedge clk); #1;
    start2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; data1 = '0; data2 = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    #2;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] basic and boundary operands");
    do_mul(32'd3, 32'd5, 32'h0000000F, 0);
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0);
    do_mul(32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 0);
    do_mul(32'd0, 32'h12345678, 32'h00000000, 0);

    $display("[TB] back-to-back with start held through DONE");
    do_mul(32'd3, 32'd5, 32'h0000000F, 1);
    do_mul(32'd2, 32'd9, 32'h00000012, 0);
    do_mul(32'd3, 32'd5, 32'h0000000F, 0);

    $display("[TB] flush in the 10th RUN cycle");
    @(posedge clk); #1;
    start = 1'b1; data1 = 32'd4; data2 = 32'd4;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle_stall", {31'd0, stall}, 32'd0);
    chk("flush_cycle_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("after_flush_busy", {31'd0, busy}, 32'd0);
    chk("after_flush_stall", {31'd0, stall}, 32'd0);
    repeat (40) @(negedge clk);
    chk("after_flush_result", result, 32'h0000000F);

    $display("[TB] asynchronous reset mid-RUN");
    @(posedge clk); #1;
    start = 1'b1; data1 = 32'd5; data2 = 32'd5;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_stall", {31'd0, stall}, 32'd0);
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_done", {31'd0, done}, 32'd0);
    chk("async_reset_result", result, 32'd0);
    start = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    do_mul(32'd7, 32'd8, 32'h00000038, 0);

    $display("[TB] two bits per cycle");
    do_mul2(32'd3, 32'd5, 32'h0000000F);
    do_mul2(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    do_mul2(32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6);

    repeat (5) @(negedge clk);
    chk("dut1_queue_drained", 32'(q1.size()), 32'd0);
    chk("dut2_queue_drained", 32'(q2.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
